// File: rtl/exu_issue_ctrl.sv
// Purpose: registered issue stage between decode and exu; holds one operand bundle, stretches multi-cycle ops, supports flush.
// Latency: 1 cycle for single-cycle ops, MC_LAT cycles for multi-cycle ops, from accept to o_post_valid.
// Backpressure: o_pre_ready follows i_post_ready when FULL (no bubble), is 0 while WAIT, and is forced to 0 by i_flush.
module exu_issue_ctrl #(
  parameter int DATA_W = 160,
  parameter int MC_LAT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_multi,
  input  logic              i_flush,
  output logic              o_post_valid,
  input  logic              i_post_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic [31:0]       o_issue_cnt,
  output logic [31:0]       o_stall_cnt
);

  localparam int CNT_W = $clog2(MC_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With MC_LAT==1 a multi-cycle op has nothing to wait for, so it takes the single-cycle path.
  localparam bit MC_EN = (MC_LAT > 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT,
    ST_FULL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pre_hs;
  logic             post_hs;
  logic             load_multi;

  // Accept whenever the stage is empty or the held bundle leaves this cycle; flush blocks any capture.
  assign o_pre_ready = !i_flush &&
                       ((state == ST_EMPTY) || ((state == ST_FULL) && i_post_ready));
  assign pre_hs      = i_pre_valid && o_pre_ready;
  assign post_hs     = o_post_valid && i_post_ready;
  assign load_multi  = i_multi && MC_EN;

  // Sequencing FSM: state, wait counter, held bundle and registered valid/busy flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_EMPTY;
      cnt          <= '0;
      o_data       <= '0;
      o_post_valid <= 1'b0;
      o_busy       <= 1'b0;
    end else if (i_flush) begin
      // Bundle is dropped but o_data keeps its last value.
      state        <= ST_EMPTY;
      cnt          <= '0;
      o_post_valid <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (pre_hs) begin
            o_data <= i_data;
            if (load_multi) begin
              state  <= ST_WAIT;
              cnt    <= CNT_INIT;
              o_busy <= 1'b1;
            end else begin
              state        <= ST_FULL;
              o_post_valid <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state        <= ST_FULL;
            o_busy       <= 1'b0;
            o_post_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (post_hs) begin
            if (pre_hs) begin
              // Swap in the next bundle in the same cycle the current one leaves.
              o_data <= i_data;
              if (load_multi) begin
                state        <= ST_WAIT;
                cnt          <= CNT_INIT;
                o_busy       <= 1'b1;
                o_post_valid <= 1'b0;
              end else begin
                state        <= ST_FULL;
                o_post_valid <= 1'b1;
              end
            end else begin
              state        <= ST_EMPTY;
              o_post_valid <= 1'b0;
            end
          end
        end
        default: begin
          state        <= ST_EMPTY;
          cnt          <= '0;
          o_post_valid <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Performance counters; a handshake in a flush cycle still counts as an issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_issue_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (post_hs) o_issue_cnt <= o_issue_cnt + 32'd1;
      if (o_post_valid && !i_post_ready) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Purpose: self-checking bench for exu_issue_ctrl with a timestamp-based reference model.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: drives random downstream ready and holds upstream bundles while not accepted.
module tb_exu_issue_ctrl;
  localparam int DATA_W = 160;
  localparam int MC_LAT = 4;

  logic              i_clk;
  logic              i_rst;
  logic              i_pre_valid;
  logic              o_pre_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_multi;
  logic              i_flush;
  logic              o_post_valid;
  logic              i_post_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_busy;
  logic [31:0]       o_issue_cnt;
  logic [31:0]       o_stall_cnt;

  int total = 0;
  int bad   = 0;

  exu_issue_ctrl #(.DATA_W(DATA_W), .MC_LAT(MC_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_data(i_data), .i_multi(i_multi), .i_flush(i_flush),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .o_data(o_data), .o_busy(o_busy),
    .o_issue_cnt(o_issue_cnt), .o_stall_cnt(o_stall_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference model: a held bundle becomes visible downstream at a cycle timestamp.
  int                cyc = 0;
  bit                m_held = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_vis = 0;
  logic [31:0]       m_issue = '0;
  logic [31:0]       m_stall = '0;

  function automatic bit m_pval();
    return m_held && (cyc >= m_vis);
  endfunction

  function automatic bit m_busy();
    return m_held && (cyc < m_vis);
  endfunction

  function automatic bit m_prdy();
    return !i_flush && (!m_held || (m_pval() && i_post_ready));
  endfunction

  task automatic m_update();
    bit pv, ph, prh;
    pv  = m_pval();
    ph  = pv && i_post_ready;
    prh = i_pre_valid && m_prdy();
    if (ph) m_issue = m_issue + 32'd1;
    if (pv && !i_post_ready) m_stall = m_stall + 32'd1;
    if (i_flush) begin
      m_held = 1'b0;
    end else begin
      if (ph) m_held = 1'b0;
      if (prh) begin
        m_held = 1'b1;
        m_data = i_data;
        m_vis  = cyc + (i_multi ? MC_LAT : 1);
      end
    end
    cyc = cyc + 1;
  endtask

  task automatic m_reset();
    m_held  = 1'b0;
    m_data  = '0;
    m_issue = '0;
    m_stall = '0;
  endtask

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Apply inputs for the current cycle and check the combinational ready.
  task automatic drive(input logic pv, input logic mul, input logic fl, input logic pr,
                       input logic [DATA_W-1:0] d);
    i_pre_valid  = pv;
    i_multi      = mul;
    i_flush      = fl;
    i_post_ready = pr;
    i_data       = d;
    #1;
    chk("pre_ready", {{(DATA_W-1){1'b0}}, o_pre_ready}, {{(DATA_W-1){1'b0}}, m_prdy()});
  endtask

  // Advance one clock and compare every registered output with the model.
  task automatic tick();
    m_update();
    @(posedge i_clk);
    #1;
    chk("post_valid", {{(DATA_W-1){1'b0}}, o_post_valid}, {{(DATA_W-1){1'b0}}, m_pval()});
    chk("busy", {{(DATA_W-1){1'b0}}, o_busy}, {{(DATA_W-1){1'b0}}, m_busy()});
    chk("data", o_data, m_data);
    chk("issue_cnt", DATA_W'(o_issue_cnt), DATA_W'(m_issue));
    chk("stall_cnt", DATA_W'(o_stall_cnt), DATA_W'(m_stall));
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i += 32) d = (d << 32) | DATA_W'($urandom);
    return d;
  endfunction

  typedef struct {
    logic        pv;
    logic        mul;
    logic        fl;
    logic        pr;
    logic [7:0]  tag;
    logic        e_prdy;
    logic        e_pval;
    logic        e_busy;
    logic [7:0]  e_tag;
    logic [31:0] e_icnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [DATA_W-1:0] s[8];
    logic [DATA_W-1:0] x, y;
    logic [31:0]       stall0, issue0;
    logic              pend;

    // Multi-cycle timing, swap, flush in WAIT (cnt=2) and flush in FULL, from reset.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1, 8'hA1, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 32'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA1, 32'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 8'hB2, 32'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 32'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 32'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 32'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3, 32'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hD4, 1'b1, 1'b1, 1'b0, 8'hD4, 32'd2};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 8'hD4, 32'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hD4, 32'd3};

    i_rst = 1'b1;
    i_pre_valid = 1'b0; i_multi = 1'b0; i_flush = 1'b0; i_post_ready = 1'b0; i_data = '0;
    #2;
    i_rst = 1'b0;

    // Table-driven directed sequence.
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].pv, tbl[k].mul, tbl[k].fl, tbl[k].pr, DATA_W'(tbl[k].tag));
      chk($sformatf("tbl%0d pre_ready", k), DATA_W'(o_pre_ready), DATA_W'(tbl[k].e_prdy));
      tick();
      chk($sformatf("tbl%0d post_valid", k), DATA_W'(o_post_valid), DATA_W'(tbl[k].e_pval));
      chk($sformatf("tbl%0d busy", k), DATA_W'(o_busy), DATA_W'(tbl[k].e_busy));
      chk($sformatf("tbl%0d data", k), o_data, DATA_W'(tbl[k].e_tag));
      chk($sformatf("tbl%0d issue_cnt", k), DATA_W'(o_issue_cnt), DATA_W'(tbl[k].e_icnt));
    end

    // Eight back-to-back single-cycle bundles with downstream always ready.
    issue0 = o_issue_cnt;
    for (int k = 0; k < 8; k++) begin
      s[k] = rand_data();
      drive(1'b1, 1'b0, 1'b0, 1'b1, s[k]);
      tick();
      chk("stream post_valid", DATA_W'(o_post_valid), DATA_W'(1'b1));
      chk("stream data", o_data, s[k]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("stream drained", DATA_W'(o_post_valid), DATA_W'(1'b0));
    chk("stream issue delta", DATA_W'(o_issue_cnt - issue0), DATA_W'(32'd8));

    // Backpressure: hold FULL for 5 cycles, then swap with a waiting bundle.
    x = rand_data();
    y = rand_data();
    drive(1'b1, 1'b0, 1'b0, 1'b0, x);
    tick();
    stall0 = o_stall_cnt;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, y);
      chk("bp pre_ready", DATA_W'(o_pre_ready), DATA_W'(1'b0));
      tick();
      chk("bp data stable", o_data, x);
    end
    chk("bp stall delta", DATA_W'(o_stall_cnt - stall0), DATA_W'(32'd5));
    drive(1'b1, 1'b0, 1'b0, 1'b1, y);
    chk("swap pre_ready", DATA_W'(o_pre_ready), DATA_W'(1'b1));
    tick();
    chk("swap post_valid", DATA_W'(o_post_valid), DATA_W'(1'b1));
    chk("swap data", o_data, y);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();

    // Asynchronous reset mid-cycle while FULL with nonzero counters.
    drive(1'b1, 1'b0, 1'b0, 1'b0, rand_data());
    tick();
    i_pre_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    m_reset();
    chk("rst post_valid", DATA_W'(o_post_valid), DATA_W'(1'b0));
    chk("rst pre_ready", DATA_W'(o_pre_ready), DATA_W'(1'b1));
    chk("rst busy", DATA_W'(o_busy), DATA_W'(1'b0));
    chk("rst data", o_data, '0);
    chk("rst issue_cnt", DATA_W'(o_issue_cnt), '0);
    chk("rst stall_cnt", DATA_W'(o_stall_cnt), '0);
    #1;
    i_rst = 1'b0;

    // Issue counter wraps from all-ones to zero.
    force dut.o_issue_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.o_issue_cnt;
    m_issue = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, 1'b0, rand_data());
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("wrap issue_cnt", DATA_W'(o_issue_cnt), '0);

    // Randomized traffic against the model; a refused bundle is held unchanged.
    pend = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (pend) begin
        drive(1'b1, i_multi, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) < 3), i_data);
      end else begin
        drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) < 3), rand_data());
      end
      pend = i_pre_valid && !m_prdy();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exu_issue_ctrl.md
# exu_issue_ctrl

Issue/sequencing controller between the decode stage and `exu`. It replaces the combinational valid/ready pass-through with one registered stage that holds the decoded operand bundle. It stretches multi-cycle operations, such as a future iterative mul/div, to a fixed latency before presenting them downstream. It also supports pipeline flush and keeps two 32-bit performance counters.

## Interface
Parameters:
- `DATA_W`, default 160: width of the captured operand/control bundle (pc, rs1, rs2, imm, selects, opt).
- `MC_LAT`, default 4: total cycles a multi-cycle op occupies the stage. Legal range is ≥1. `MC_LAT`=1 makes multi-cycle ops behave exactly as single-cycle ops.

Ports:
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_pre_valid` input 1: upstream bundle valid.
- `o_pre_ready` output 1: stage can accept a bundle this cycle.
- `i_data` input `DATA_W`: upstream bundle.
- `i_multi` input 1: bundle is a multi-cycle op; sampled with `i_data`.
- `i_flush` input 1: discard held bundle (branch/trap redirect).
- `o_post_valid` output 1: bundle presented to `exu`/downstream.
- `i_post_ready` input 1: downstream accepts.
- `o_data` output `DATA_W`: held bundle.
- `o_busy` output 1: stage in WAIT.
- `o_issue_cnt` output 32: count of downstream handshakes.
- `o_stall_cnt` output 32: count of cycles with `o_post_valid`=1 and `i_post_ready`=0.

## Operation
State machine with states EMPTY, WAIT and FULL, plus a down-counter `cnt` of width clog2(`MC_LAT`+1).

- **EMPTY**
  - `o_pre_ready`=1, `o_post_valid`=0.
  - On pre-handshake, capture `i_data` into `o_data`.
  - If `i_multi`=1 and `MC_LAT`>1: go to WAIT with `cnt`=`MC_LAT`-1.
  - Otherwise: go to FULL.
- **WAIT**
  - `o_pre_ready`=0, `o_post_valid`=0, `o_busy`=1.
  - `cnt` decrements each cycle.
  - When `cnt`==1, the next state is FULL.
- **FULL**
  - `o_post_valid`=1.
  - `o_pre_ready`=`i_post_ready`, giving back-to-back issue with no bubble.
  - Post-handshake with a simultaneous pre-handshake: capture the new bundle and go to WAIT or FULL per the EMPTY rules.
  - Post-handshake alone: go to EMPTY.
  - No post-handshake: hold; `o_data` must stay stable while `o_post_valid`=1.
- **Flush**
  - `i_flush`=1 has priority over everything.
  - `o_pre_ready` is forced to 0 combinationally.
  - Next state is EMPTY from any state; `cnt` is cleared.
  - A downstream handshake occurring in the flush cycle still counts in `o_issue_cnt`.
  - `o_data` is not cleared.
- **Counters**
  - Both counters wrap modulo 2^32 and are never cleared except by reset.
  - `o_stall_cnt` increments in any cycle with `o_post_valid`=1 and `i_post_ready`=0.
- **Reset values**
  - State EMPTY, `cnt`=0, `o_data`=0.
  - `o_post_valid`=0, `o_busy`=0, `o_pre_ready`=1.
  - Both counters 0.
  - Reset asserted mid-WAIT or mid-FULL drops the bundle immediately (asynchronous).

## Timing
- All outputs are registered except `o_pre_ready`, which is combinational from state, `i_post_ready` and `i_flush`.
- Single-cycle op:
  - Accepted at edge E.
  - `o_post_valid`=1 in the cycle after E (latency 1).
- Multi-cycle op:
  - Accepted at edge E.
  - WAIT for `MC_LAT`-1 cycles.
  - `o_post_valid`=1 from the `MC_LAT`-th cycle after E.
- Sustained single-cycle throughput is 1 bundle per cycle when `i_post_ready`=1.
- Multi-cycle throughput is 1 bundle per `MC_LAT` cycles.
- The upstream may not change `i_data` while `i_pre_valid`=1 and `o_pre_ready`=0. The block does not check this.

## Test plan
- **Reset:** with `i_rst`=1 asserted asynchronously mid-cycle -> `o_post_valid`=0, `o_pre_ready`=1, `o_data`=0, counters 0, without waiting for a clock edge.
- **Single-cycle stream:** 8 back-to-back bundles, `i_multi`=0, `i_post_ready`=1 -> one `o_post_valid` per cycle starting 1 cycle after the first accept, `o_data` in order, `o_issue_cnt`=8.
- **Multi-cycle, `MC_LAT`=4:** bundle A accepted at cycle 0 -> `o_busy`=1 in cycles 1–3, `o_post_valid`=1 at cycle 4, `o_pre_ready`=0 in cycles 1–3.
- **Backpressure:** FULL with `i_post_ready`=0 for 5 cycles -> `o_data` stable, `o_pre_ready`=0, `o_stall_cnt`=5; raising `i_post_ready` with `i_pre_valid`=1 -> swap in the same cycle, `o_post_valid` stays 1.
- **Flush:**
  - Flush in WAIT with `cnt`=2 -> EMPTY next cycle, no `o_post_valid` for that bundle.
  - Flush in FULL with `i_pre_valid`=1 and `i_post_ready`=1 -> new bundle not captured, `o_issue_cnt` +1.
- **Counter wrap:** preload `o_issue_cnt` to 0xFFFFFFFF via force, then one handshake -> 0x00000000.
